// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder: adds or subtracts two NUMBITS operands as a ripple of
// CHUNKBITS-wide slices, one slice per clock, LSB slice first. Subtraction uses
// A + ~B + 1, so carryout = 1 means no borrow. A completed result stays on the
// outputs until the next operation overwrites it.
module multicycle_chunk_adder #(
    parameter int unsigned NUMBITS   = 8,
    parameter int unsigned CHUNKBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sub,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow
);

    localparam int unsigned NCHUNKS = NUMBITS / CHUNKBITS;
    localparam int unsigned IDXW    = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [NUMBITS-1:0]   a_reg;
    logic [NUMBITS-1:0]   b_reg;
    logic                 carry_reg;
    logic [IDXW-1:0]      idx;

    logic [31:0]          chunk_base;
    logic [CHUNKBITS-1:0] a_chunk;
    logic [CHUNKBITS-1:0] b_chunk;
    logic [CHUNKBITS:0]   chunk_sum;
    logic                 last_chunk;
    logic                 accept;

    // Slice adder for the chunk currently selected by idx.
    always_comb begin
        chunk_base = 32'(idx) * CHUNKBITS;
        a_chunk    = a_reg[chunk_base +: CHUNKBITS];
        b_chunk    = b_reg[chunk_base +: CHUNKBITS];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk}
                   + {{CHUNKBITS{1'b0}}, carry_reg};
        last_chunk = (idx == LAST_IDX);
        accept     = start && ((state == S_IDLE) || (state == S_DONE));
    end

    // FSM, operand capture and per-chunk result/carry update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_reg     <= A;
                        b_reg     <= B ^ {NUMBITS{sub}};
                        carry_reg <= sub;
                        idx       <= '0;
                        state     <= S_RUN;
                    end else begin
                        state     <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result[chunk_base +: CHUNKBITS] <= chunk_sum[CHUNKBITS-1:0];
                    carry_reg <= chunk_sum[CHUNKBITS];
                    if (last_chunk) begin
                        // The top slice's sum bit is the result MSB, so overflow
                        // is judged here rather than from the registered result.
                        carryout <= chunk_sum[CHUNKBITS];
                        overflow <= (a_reg[NUMBITS-1] == b_reg[NUMBITS-1]) &&
                                    (chunk_sum[CHUNKBITS-1] != a_reg[NUMBITS-1]);
                        idx      <= '0;
                        state    <= S_DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Directed bench for multicycle_chunk_adder at NUMBITS=16, CHUNKBITS=4.
module tb_multicycle_chunk_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carryout;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    multicycle_chunk_adder #(.NUMBITS(16), .CHUNKBITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present an operation for exactly one edge, then scramble the operands.
    task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        sub   = s;
        A     = a;
        B     = b;
        step;
        start = 1'b0;
        sub   = 1'($urandom);
        A     = 16'($urandom);
        B     = 16'($urandom);
    endtask

    // Count busy cycles until done, bounded.
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            step;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int nb;
        bit got;
        launch(v.sub, v.a, v.b);
        wait_done(nb, got);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd4);
        check({tag, "_result"}, 32'(result), 32'(v.res));
        check({tag, "_carryout"}, 32'(carryout), 32'(v.c));
        check({tag, "_overflow"}, 32'(overflow), 32'(v.v));
        step;
        check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
        check({tag, "_idle_hold"}, 32'(result), 32'(v.res));
    endtask

    initial begin
        int  nb;
        bit  got;
        int  dones;

        vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        A     = '0;
        B     = '0;
        step;
        step;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carryout", 32'(carryout), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        A     = 16'h1111;
        B     = 16'h2222;
        step;
        check("reset_vs_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        step;
        check("after_reset_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Chunk-by-chunk result update; overflow holds until the last chunk.
        run_vec("prime_ovf", vecs[2]);
        launch(1'b0, 16'h1234, 16'h1111);
        step;
        step;
        check("mid_run_result", 32'(result), 32'h8045);
        check("mid_run_overflow_hold", 32'(overflow), 32'd1);
        check("mid_run_busy", 32'(busy), 32'd1);
        wait_done(nb, got);
        check("mid_run_final", 32'(result), 32'h2345);

        // Start during busy is ignored; start held in DONE chains without a gap.
        step;
        launch(1'b0, 16'h1234, 16'h1111);
        start = 1'b1;
        A     = 16'hFFFF;
        B     = 16'hFFFF;
        step;
        step;
        step;
        start = 1'b0;
        step;
        check("ignore_start_done", 32'(done), 32'd1);
        check("ignore_start_result", 32'(result), 32'h2345);
        launch(1'b0, 16'h0001, 16'h0001);
        check("b2b_busy_after_done", 32'(busy), 32'd1);
        wait_done(nb, got);
        check("b2b_done_seen", 32'(got), 32'd1);
        check("b2b_busy_cycles", 32'(nb), 32'd4);
        check("b2b_result", 32'(result), 32'h0002);
        step;
        check("b2b_single_done", 32'(done), 32'd0);

        // Reset mid-run aborts with no done pulse.
        launch(1'b0, 16'h1234, 16'h1111);
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carryout", 32'(carryout), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            step;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        launch(1'b0, 16'h00FF, 16'h0001);
        wait_done(nb, got);
        check("post_abort_done_seen", 32'(got), 32'd1);
        check("post_abort_busy_cycles", 32'(nb), 32'd4);
        check("post_abort_result", 32'(result), 32'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_chunk_adder.md
MULTICYCLE_CHUNK_ADDER -- requirements
Module: multicycle_chunk_adder

Interface
REQ-001 The block SHALL have parameter NUMBITS, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNKBITS, default 4, giving the ripple-slice width added per cycle.
REQ-003 NUMBITS SHALL be an integer multiple of CHUNKBITS, with NCHUNKS = NUMBITS/CHUNKBITS derived internally.
REQ-004 The block SHALL use one clock and one synchronous, active-high reset.
REQ-005 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request to launch an operation.
- sub  input  1  mode select: 0 = A+B, 1 = A-B.
- A  input  NUMBITS  operand A, unsigned or two's-complement.
- B  input  NUMBITS  operand B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse marking the result as valid.
- result  output  NUMBITS  sum or difference, modulo 2^NUMBITS.
- carryout  output  1  final carry; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Function
REQ-006 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-007 start SHALL be sampled only in IDLE or DONE; start=1 there at a rising edge SHALL do all of the following:
- latch A as a_reg.
- latch B XOR {NUMBITS{sub}} as b_reg.
- set carry_reg = sub.
- clear the chunk index to 0.
- go to RUN.
REQ-008 Each RUN cycle SHALL compute {c, s} = a_reg[chunk] + b_reg[chunk] + carry_reg over CHUNKBITS+1 bits, then:
- write s into result[idx*CHUNKBITS +: CHUNKBITS].
- update carry_reg = c.
- increment idx.
REQ-009 Chunks SHALL be processed LSB-first, and chunk idx SHALL consume the carry from chunk idx-1 only.
REQ-010 On the RUN cycle that processes chunk NCHUNKS-1, the FSM SHALL go to DONE and register the final values:
- carryout = final carry.
- overflow = (a_reg[MSB] == b_reg[MSB]) && (sum[MSB] != a_reg[MSB]).
REQ-011 busy SHALL be 1 exactly while in RUN.
REQ-012 done SHALL be 1 exactly while in DONE, which lasts one cycle.
REQ-013 Latency: with start sampled at edge E, done SHALL be high in the cycle after edge E+NCHUNKS, i.e. busy for NCHUNKS cycles.
REQ-014 With CHUNKBITS == NUMBITS, the block SHALL complete in a single RUN cycle (NCHUNKS = 1).
REQ-015 DONE SHALL go to IDLE when start=0, and SHALL go directly to RUN when start=1, allowing back-to-back operations with no gap.
REQ-016 start while busy=1 SHALL be ignored: operands are not relatched and the operation in flight is unaffected.
REQ-017 A, B and sub SHALL be don't-care except at the accepting edge.
REQ-018 result, carryout and overflow SHALL hold their last completed values in IDLE and DONE.
REQ-019 During RUN, result SHALL update chunk by chunk, and carryout/overflow SHALL keep their previous values until the final chunk.
REQ-020 Wrap-around: results SHALL be taken modulo 2^NUMBITS, with the excess reported only on carryout.

Reset
REQ-021 reset=1 at a rising edge SHALL do all of the following:
- force state to IDLE.
- set busy=0, done=0, result=0, carryout=0, overflow=0.
- clear a_reg, b_reg, carry_reg and idx.
REQ-022 Reset SHALL take priority over start, including when both are 1 on the same edge.
REQ-023 Reset asserted mid-RUN SHALL abort the operation, with no done pulse for the aborted operation.
REQ-024 The first start after reset is released SHALL be accepted normally.

Verification (NUMBITS=16, CHUNKBITS=4, NCHUNKS=4)
REQ-025 start, sub=0, A=0000, B=0000 -> busy high 4 cycles, then done pulse with result=0000, carryout=0, overflow=0.
REQ-026 start, sub=0, A=FFFF, B=0001 -> result=0000, carryout=1, overflow=0; the carry SHALL ripple through all 4 chunks.
REQ-027 start, sub=0, A=7FFF, B=0001 -> result=8000, carryout=0, overflow=1.
REQ-028 start, sub=1, A=0005, B=0007 -> result=FFFE, carryout=0 (borrow), overflow=0; then sub=1, A=8000, B=0001 -> result=7FFF, carryout=1, overflow=1.
REQ-029 start A=1234, B=1111, then start with A=FFFF, B=FFFF during busy -> single done with result=2345; then start held high in DONE with A=0001, B=0001 -> next done after 4 busy cycles with result=0002.
REQ-030 reset asserted after 2 RUN cycles -> next cycle busy=0, done=0, result=0000, no done pulse; a subsequent start with A=00FF, B=0001 -> result=0100.
